// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared field positions and forwarding helper for the decode queue
package decode_pkg;

    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB  = 7;
    localparam int REG_W   = 5;

    // True when a writeback targets the named source register; x0 never matches.
    function automatic logic fwd_sel(
        input logic             we,
        input logic [REG_W-1:0] wb_rd,
        input logic [REG_W-1:0] rs
    );
        return we && (wb_rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - DEPTH-entry FIFO with wrap-bit pointers and occupancy count
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   clear                empties the FIFO at the next edge (push/pop ignored)
//   push, push_data      write an entry at the tail
//   pop                  advance the head
//   head_data            entry at the head (valid when !empty)
//   full, empty, count   occupancy status
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    diff;

    assign empty     = (head == tail);
    // Same slot index, different lap: the tail has lapped the head.
    assign full      = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
    assign head_data = mem[head[AW-1:0]];
    assign diff      = tail - head;
    assign count     = CW'(diff);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[tail[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - instruction queue plus registered decode slot with operand forwarding
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   flush                            drop queued and held instructions
//   in_valid/in_ready/in_instr/in_pc fetch side handshake
//   out_valid/out_ready/out_*        execute side handshake and held decode fields
//   rf_a1/rf_a2, rf_rd1/rf_rd2       register-file read port (combinational data)
//   wb_we/wb_rd/wb_data              writeback bus, forwarded into captured/held operands
//   count                            queue occupancy, not counting the output slot
module decode_queue
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic [REG_W-1:0] out_rs1,
    output logic [REG_W-1:0] out_rs2,
    output logic [REG_W-1:0] out_rd,
    output logic [XLEN-1:0]  out_rd1,
    output logic [XLEN-1:0]  out_rd2,
    output logic [REG_W-1:0] rf_a1,
    output logic [REG_W-1:0] rf_a2,
    input  logic [XLEN-1:0]  rf_rd1,
    input  logic [XLEN-1:0]  rf_rd2,
    input  logic             wb_we,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic [CW-1:0]    count
);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } q_entry_t;

    localparam int QW = $bits(q_entry_t);

    q_entry_t         in_e;
    q_entry_t         head_e;
    q_entry_t         src_e;
    logic             full;
    logic             empty;
    logic             load;
    logic             bypass;
    logic             has_src;
    logic             take;
    logic             pop;
    logic             push;
    logic [REG_W-1:0] src_rs1;
    logic [REG_W-1:0] src_rs2;
    logic [REG_W-1:0] src_rd;

    assign in_e.instr = in_instr;
    assign in_e.pc    = in_pc;

    // Depends only on stored state and flush, so execute backpressure
    // never reaches fetch combinationally.
    assign in_ready = !full && !flush;
    assign load     = !out_valid || out_ready;

    // The queue always has priority so program order is preserved; fetch
    // bypasses straight into the slot only when nothing is waiting.
    assign bypass  = empty && in_valid;
    assign has_src = !empty || in_valid;
    assign src_e   = bypass ? in_e : head_e;
    assign src_rs1 = src_e.instr[RS1_LSB +: REG_W];
    assign src_rs2 = src_e.instr[RS2_LSB +: REG_W];
    assign src_rd  = src_e.instr[RD_LSB +: REG_W];

    assign rf_a1 = src_rs1;
    assign rf_a2 = src_rs2;

    assign take = load && has_src && !flush;
    assign pop  = take && !empty;
    // An instruction consumed by the bypass must not also be queued.
    assign push = in_valid && in_ready && !(take && bypass);

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (QW),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (push),
        .push_data (in_e),
        .pop       (pop),
        .head_data (head_e),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
            out_rs1   <= '0;
            out_rs2   <= '0;
            out_rd    <= '0;
            out_rd1   <= '0;
            out_rd2   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= has_src;
            if (has_src) begin
                out_instr <= src_e.instr;
                out_pc    <= src_e.pc;
                out_rs1   <= src_rs1;
                out_rs2   <= src_rs2;
                out_rd    <= src_rd;
                // The register file has not seen this cycle's writeback yet.
                out_rd1   <= fwd_sel(wb_we, wb_rd, src_rs1) ? wb_data : rf_rd1;
                out_rd2   <= fwd_sel(wb_we, wb_rd, src_rs2) ? wb_data : rf_rd2;
            end
        end else if (out_valid) begin
            // Held instruction: keep operands current while execute stalls.
            if (fwd_sel(wb_we, wb_rd, out_rs1)) out_rd1 <= wb_data;
            if (fwd_sel(wb_we, wb_rd, out_rs2)) out_rd2 <= wb_data;
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - self-checking bench for decode_queue
module tb_decode_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [31:0] out_rd1, out_rd2;
    logic [4:0]  rf_a1, rf_a2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decode_queue #(.XLEN(32), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_rs1   (out_rs1),
        .out_rs2   (out_rs2),
        .out_rd    (out_rd),
        .out_rd1   (out_rd1),
        .out_rd2   (out_rd2),
        .rf_a1     (rf_a1),
        .rf_a2     (rf_a2),
        .rf_rd1    (rf_rd1),
        .rf_rd2    (rf_rd2),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .count     (count)
    );

    // Register file stand-in: x3 returns a stale 0x11, x0 reads zero.
    function automatic logic [31:0] rf_val(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (a == 5'd3) return 32'h11;
        return 32'h1000 + {27'h0, a};
    endfunction

    assign rf_rd1 = rf_val(rf_a1);
    assign rf_rd2 = rf_val(rf_a2);

    // Instruction k: rs1=k, rs2=k+1, rd=k.
    function automatic logic [31:0] mk(input int k);
        logic [4:0] r;
        logic [4:0] r2;
        r  = 5'(k);
        r2 = 5'(k + 1);
        return {7'h0, r2, r, 3'h0, r, 7'h33};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 30) $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_pc;
        int          e_cnt;
        logic        e_ir;
        logic [4:0]  e_rs1;
    } vec_t;

    vec_t vecs[14];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t sb[$];

    initial begin
        vecs[0]  = '{1'b1, 32'h00208033, 32'h100, 1'b1, 1'b1, 32'h100, 0, 1'b1, 5'd1};
        vecs[1]  = '{1'b0, 32'h0,        32'h0,   1'b1, 1'b0, 32'h0,   0, 1'b1, 5'd0};
        vecs[2]  = '{1'b1, mk(1),        32'h104, 1'b0, 1'b1, 32'h104, 0, 1'b1, 5'd1};
        vecs[3]  = '{1'b1, mk(2),        32'h108, 1'b0, 1'b1, 32'h104, 1, 1'b1, 5'd1};
        vecs[4]  = '{1'b1, mk(3),        32'h10c, 1'b0, 1'b1, 32'h104, 2, 1'b1, 5'd1};
        vecs[5]  = '{1'b1, mk(4),        32'h110, 1'b0, 1'b1, 32'h104, 3, 1'b1, 5'd1};
        vecs[6]  = '{1'b1, mk(5),        32'h114, 1'b0, 1'b1, 32'h104, 4, 1'b0, 5'd1};
        vecs[7]  = '{1'b1, mk(6),        32'h118, 1'b0, 1'b1, 32'h104, 4, 1'b0, 5'd1};
        vecs[8]  = '{1'b1, mk(6),        32'h118, 1'b1, 1'b1, 32'h108, 3, 1'b1, 5'd2};
        vecs[9]  = '{1'b1, mk(6),        32'h118, 1'b1, 1'b1, 32'h10c, 3, 1'b1, 5'd3};
        vecs[10] = '{1'b0, 32'h0,        32'h0,   1'b1, 1'b1, 32'h110, 2, 1'b1, 5'd4};
        vecs[11] = '{1'b0, 32'h0,        32'h0,   1'b1, 1'b1, 32'h114, 1, 1'b1, 5'd5};
        vecs[12] = '{1'b0, 32'h0,        32'h0,   1'b1, 1'b1, 32'h118, 0, 1'b1, 5'd6};
        vecs[13] = '{1'b0, 32'h0,        32'h0,   1'b1, 1'b0, 32'h0,   0, 1'b1, 5'd0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        step; step;
        rst_n = 1'b1;
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset count",     32'(count),     32'd0);
        chk("reset in_ready",  32'(in_ready),  32'd1);
        chk("reset out_pc",    out_pc,         32'd0);

        // Bypass latency, fill, backpressure and in-order drain.
        for (int i = 0; i < 14; i++) begin
            in_valid  = vecs[i].iv;
            in_instr  = vecs[i].instr;
            in_pc     = vecs[i].pc;
            out_ready = vecs[i].ordy;
            step;
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d count", i),     32'(count),     32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
            if (vecs[i].e_ov) begin
                chk($sformatf("vec%0d out_pc", i),  out_pc,         vecs[i].e_pc);
                chk($sformatf("vec%0d out_rs1", i), 32'(out_rs1),   32'(vecs[i].e_rs1));
            end
        end
        in_valid = 1'b0; in_instr = '0;

        // Hold forwarding with rs1 == rs2 == x5.
        in_valid = 1'b1; in_instr = 32'h0052_80b3; in_pc = 32'h200; out_ready = 1'b0;
        step;
        chk("hold load rd1", out_rd1, 32'h1005);
        chk("hold load rs2", 32'(out_rs2), 32'd5);
        in_valid = 1'b0; wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        step;
        chk("hold fwd rd1", out_rd1, 32'hDEADBEEF);
        chk("hold fwd rd2", out_rd2, 32'hDEADBEEF);
        wb_rd = 5'd0; wb_data = 32'h12345678;
        step;
        chk("hold x0 wb rd1", out_rd1, 32'hDEADBEEF);
        wb_we = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0000_0033; in_pc = 32'h204; out_ready = 1'b1;
        step;
        chk("x0 slot pc", out_pc, 32'h204);
        in_valid = 1'b0; out_ready = 1'b0; wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hAAAA;
        step;
        chk("x0 no fwd rd1", out_rd1, 32'h0);
        chk("x0 no fwd rd2", out_rd2, 32'h0);

        // Forwarding on the load edge over a stale register-file value.
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h22;
        in_valid = 1'b1; in_instr = 32'h0041_8133; in_pc = 32'h208; out_ready = 1'b1;
        step;
        chk("load fwd rd1", out_rd1, 32'h22);
        chk("load rf rd2",  out_rd2, 32'h1004);
        wb_we = 1'b0;

        // Flush with three queued and one held.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_instr = mk(10 + k); in_pc = 32'h300 + 32'(4 * k);
            step;
        end
        chk("pre-flush count", 32'(count), 32'd3);
        chk("pre-flush valid", 32'(out_valid), 32'd1);
        flush = 1'b1; in_valid = 1'b1; in_instr = mk(20); in_pc = 32'h400; out_ready = 1'b1;
        #1;
        chk("flush in_ready", 32'(in_ready), 32'd0);
        step;
        chk("post-flush valid", 32'(out_valid), 32'd0);
        chk("post-flush count", 32'(count), 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        step;
        chk("after flush valid", 32'(out_valid), 32'd0);
        chk("after flush count", 32'(count), 32'd0);

        // Reset while full.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_instr = mk(k + 1); in_pc = 32'h500 + 32'(4 * k);
            step;
        end
        chk("full in_ready", 32'(in_ready), 32'd0);
        chk("full count", 32'(count), 32'd4);
        in_valid = 1'b0; rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        #1;
        chk("mid reset out_valid", 32'(out_valid), 32'd0);
        chk("mid reset count",     32'(count),     32'd0);
        chk("mid reset in_ready",  32'(in_ready),  32'd1);
        chk("mid reset out_instr", out_instr,      32'd0);
        chk("mid reset out_rd1",   out_rd1,        32'd0);

        // Random valid/ready/flush against a reference queue.
        wb_we = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            logic iv_s, ir_s, ov_s, or_s, fl_s;
            logic [31:0] ins_s, pc_s;
            ent_t e;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = $urandom;
            in_pc     = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 99) == 0);
            #1;
            iv_s = in_valid; ir_s = in_ready; ov_s = out_valid; or_s = out_ready; fl_s = flush;
            ins_s = in_instr; pc_s = in_pc;
            step;
            if (fl_s) begin
                sb.delete();
            end else begin
                if (ov_s && or_s) void'(sb.pop_front());
                if (iv_s && ir_s) begin
                    e.instr = ins_s; e.pc = pc_s;
                    sb.push_back(e);
                end
            end
            chk("stress out_valid", 32'(out_valid), 32'(sb.size() != 0));
            chk("stress count", 32'(count), 32'(sb.size() - ((sb.size() != 0) ? 1 : 0)));
            if (sb.size() != 0) begin
                chk("stress out_pc", out_pc, sb[0].pc);
                chk("stress out_instr", out_instr, sb[0].instr);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
